// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY transmit lane sequencer:
// state encoding, LP line codes, HS sync byte and timing defaults.
package dphy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLK_PRE  = 4'd1,
    ST_LPX      = 4'd2,
    ST_PREP     = 4'd3,
    ST_ZERO     = 4'd4,
    ST_SYNC     = 4'd5,
    ST_DATA     = 4'd6,
    ST_TRAIL    = 4'd7,
    ST_CLK_POST = 4'd8,
    ST_EXIT     = 4'd9
  } dphy_state_e;

  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam int T_CLK_PRE_DEF  = 8;
  localparam int T_LPX_DEF      = 4;
  localparam int T_HS_PREP_DEF  = 4;
  localparam int T_HS_ZERO_DEF  = 10;
  localparam int T_HS_TRAIL_DEF = 6;
  localparam int T_CLK_POST_DEF = 8;

  function automatic int tmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Trail level is the complement of the final payload bit so the line toggles.
  function automatic logic [7:0] trail_byte_of(input logic [7:0] last_byte);
    return last_byte[7] ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/dphy_tx_trail_gen.sv
// Per-lane HS trail byte, derived from the byte last displayed on that lane.
module dphy_tx_trail_gen
  import dphy_pkg::*;
(
  input  logic [7:0] last_byte,
  output logic [7:0] trail_byte
);

  assign trail_byte = trail_byte_of(last_byte);

endmodule

// File: rtl/dphy_tx_lane_seq.sv
// MIPI D-PHY transmit lane sequencer: LP-to-HS entry, payload handshake,
// HS trail/exit and underrun recovery for one clock lane and NUM_LANES data lanes.
module dphy_tx_lane_seq
  import dphy_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int T_CLK_PRE  = T_CLK_PRE_DEF,
  parameter int T_LPX      = T_LPX_DEF,
  parameter int T_HS_PREP  = T_HS_PREP_DEF,
  parameter int T_HS_ZERO  = T_HS_ZERO_DEF,
  parameter int T_HS_TRAIL = T_HS_TRAIL_DEF,
  parameter int T_CLK_POST = T_CLK_POST_DEF
) (
  input  logic                   i_clk,
  input  logic                   reset_n,
  input  logic                   pkt_valid,
  input  logic [8*NUM_LANES-1:0] pkt_data,
  input  logic                   pkt_last,
  output logic                   pkt_ready,
  output logic [8*NUM_LANES-1:0] byte_d,
  output logic [2*NUM_LANES-1:0] lp_out,
  output logic [NUM_LANES-1:0]   lp_dir,
  output logic                   hs_clk_en,
  output logic                   hs_data_en,
  output logic                   busy,
  output logic                   underrun
);

  localparam int BW    = 8 * NUM_LANES;
  localparam int T_MAX = tmax(tmax(tmax(T_CLK_PRE, T_LPX), tmax(T_HS_PREP, T_HS_ZERO)),
                              tmax(T_HS_TRAIL, T_CLK_POST));
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The counter holds "cycles left after this one", so a state lasts t cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int t);
    return CNT_W'(t - 1);
  endfunction

  dphy_state_e              state_r, state_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;
  logic [BW-1:0]            byte_r, byte_s, trail_s;
  logic                     last_r, last_s;
  logic                     underrun_r, underrun_s;
  logic [2*NUM_LANES-1:0]   lp_r, lp_s;
  logic [NUM_LANES-1:0]     lp_dir_r;
  logic                     hs_clk_r, hs_clk_s;
  logic                     hs_data_r, hs_data_s;
  logic                     busy_r, busy_s;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_trail
    dphy_tx_trail_gen u_trail (
      .last_byte  (byte_r[8*k +: 8]),
      .trail_byte (trail_s[8*k +: 8])
    );
  end

  assign pkt_ready  = (state_r == ST_SYNC) | ((state_r == ST_DATA) & ~last_r);
  assign byte_d     = byte_r;
  assign lp_out     = lp_r;
  assign lp_dir     = lp_dir_r;
  assign hs_clk_en  = hs_clk_r;
  assign hs_data_en = hs_data_r;
  assign busy       = busy_r;
  assign underrun   = underrun_r;

  // Next state, counter reload and the byte to display next cycle.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    byte_s     = {BW{1'b0}};
    last_s     = 1'b0;
    underrun_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pkt_valid) begin
          state_s = ST_CLK_PRE;
          cnt_s   = cnt_load(T_CLK_PRE);
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      ST_CLK_PRE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_LPX;
          cnt_s   = cnt_load(T_LPX);
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_LPX: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_PREP;
          cnt_s   = cnt_load(T_HS_PREP);
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_PREP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_ZERO;
          cnt_s   = cnt_load(T_HS_ZERO);
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_ZERO: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_SYNC;
          cnt_s   = CNT_ZERO;
          byte_s  = {NUM_LANES{SYNC_BYTE}};
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_SYNC, ST_DATA: begin
        // Missing beat while ready (underrun) or the last beat shown: close the burst.
        if ((state_r == ST_DATA) && last_r) begin
          state_s = ST_TRAIL;
          cnt_s   = cnt_load(T_HS_TRAIL);
          byte_s  = trail_s;
        end else if (pkt_valid) begin
          state_s = ST_DATA;
          byte_s  = pkt_data;
          last_s  = pkt_last;
        end else begin
          state_s    = ST_TRAIL;
          cnt_s      = cnt_load(T_HS_TRAIL);
          byte_s     = trail_s;
          underrun_s = 1'b1;
        end
      end
      ST_TRAIL: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_CLK_POST;
          cnt_s   = cnt_load(T_CLK_POST);
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
          byte_s  = byte_r;
        end
      end
      ST_CLK_POST: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_EXIT;
          cnt_s   = cnt_load(T_LPX);
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_EXIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line levels and enables decoded from the state being entered.
  always_comb begin
    lp_s      = {NUM_LANES{LP_11}};
    hs_clk_s  = 1'b1;
    hs_data_s = 1'b0;
    busy_s    = 1'b1;
    case (state_s)
      ST_IDLE: begin
        hs_clk_s = 1'b0;
        busy_s   = 1'b0;
      end
      ST_CLK_PRE:  lp_s = {NUM_LANES{LP_11}};
      ST_LPX:      lp_s = {NUM_LANES{LP_01}};
      ST_PREP:     lp_s = {NUM_LANES{LP_00}};
      ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL: begin
        lp_s      = {NUM_LANES{LP_00}};
        hs_data_s = 1'b1;
      end
      ST_CLK_POST: lp_s = {NUM_LANES{LP_11}};
      ST_EXIT:     hs_clk_s = 1'b0;
      default: begin
        hs_clk_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      byte_r     <= {BW{1'b0}};
      last_r     <= 1'b0;
      underrun_r <= 1'b0;
      lp_r       <= {NUM_LANES{LP_11}};
      lp_dir_r   <= {NUM_LANES{1'b1}};
      hs_clk_r   <= 1'b0;
      hs_data_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      byte_r     <= byte_s;
      last_r     <= last_s;
      underrun_r <= underrun_s;
      lp_r       <= lp_s;
      lp_dir_r   <= {NUM_LANES{1'b1}};
      hs_clk_r   <= hs_clk_s;
      hs_data_r  <= hs_data_s;
      busy_r     <= busy_s;
    end
  end

endmodule
